spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
Round-robin scheduler that shares one spi_master between NUM_REQ on-chip requesters. Per transaction it latches the winning requester's payload and config (tx word, slave select, length, CPOL/CPHA) and drives the master's start/config inputs. It then tracks the master's busy handshake and returns rx data with a one-cycle done pulse. It sits between client logic and spi_master, so clients never touch the master's start/busy protocol directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant index (must hold NUM_REQ-1)
START_TIMEOUT, 15, clk cycles allowed for m_busy to rise after m_start asserts (max 255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level
req_tx_data  in  NUM_REQ*32  tx word, requester i at bits [32i+31:32i]
req_cs  in  NUM_REQ*3  slave select index
req_len  in  NUM_REQ*2  transaction_length code (0=8b,1=16b,2=24b,3=32b)
req_cpol  in  NUM_REQ  clock polarity
req_cpha  in  NUM_REQ  clock phase
done  out  NUM_REQ  one-cycle completion pulse
err  out  NUM_REQ  one-cycle start-timeout pulse
rx_data  out  32  rx word, valid in the done cycle and held until next done
grant_id  out  ID_W  index of the current/last granted requester
arb_busy  out  1  high from grant until done/err
m_start  out  1  to spi_master start_trans
m_busy  in  1  from spi_master busy
m_tx_data  out  32  to spi_master tx_data
m_rx_data  in  32  from spi_master rx_data
m_cs_sel  out  3  to spi_master chip-select index
m_len  out  2  to spi_master transaction_length
m_cpol  out  1  to spi_master CPOL
m_cpha  out  1  to spi_master CPHA

Behaviour:
- Reset (rst low, async): state IDLE. m_start, done, err, arb_busy = 0. rx_data, m_tx_data = 0. m_cs_sel, m_len, m_cpol, m_cpha = 0. grant_id = 0. Round-robin pointer = 0.
- Reset mid-transaction: outputs return to reset values immediately. No done/err is issued for the aborted request.
- States: IDLE -> SETUP -> START -> RUN -> DONE -> IDLE. START -> FAIL -> IDLE on timeout.
- IDLE: if any req is high, grant the first requester at or after the pointer, scanning upward with wrap (NUM_REQ-1 -> 0).
  - In the same edge: latch that requester's payload/config into m_* registers, set grant_id, set arb_busy=1, advance the pointer to grant+1 (mod NUM_REQ).
- SETUP: one cycle with config stable and m_start=0, so the master sees the new CPOL idle level before SCLK starts.
- START: m_start=1, held until m_busy is sampled high.
  - On m_busy high: m_start=0, go to RUN.
  - The timeout counter counts START cycles. If it reaches START_TIMEOUT with m_busy still low: go to FAIL with m_start=0.
- RUN: wait for m_busy low, then go to DONE.
- DONE: capture m_rx_data into rx_data, pulse done[grant_id] for one cycle, clear arb_busy, go to IDLE.
- FAIL: pulse err[grant_id] for one cycle, clear arb_busy, leave rx_data unchanged, go to IDLE.
- Minimum gap between transactions: after DONE, the next grant comes on the IDLE cycle, with no back-to-back skip of SETUP.
- Payload is sampled only at grant. Later changes to req_* for that requester are ignored until the next grant.
- A requester dropping req mid-transaction does not abort; done/err is still pulsed.
- Requester protocol: hold req until the done/err pulse. If req is still high in the IDLE cycle after its done, it is eligible again but loses priority to any other pending requester.
- m_busy already high in IDLE (master not yet idle): grants are suppressed until m_busy is low.
- Latency, req rise to m_start: 2 cycles (grant edge + SETUP). From m_busy fall to done: 1 cycle.

Decomposition:
- Package spi_arb_pkg holds:
  - state encoding enum (IDLE, SETUP, START, RUN, DONE, FAIL)
  - length codes LEN_8/16/24/32
  - the 32-bit data width constant
- One natural sub-module: spi_rr_picker, a combinational round-robin priority picker (req vector + pointer -> grant index + valid). Everything else stays in the top FSM.

Test Plan:
- Single request: req[0] with tx=0xAA, len=0, CPOL=0, CPHA=1, slave loopback returning 0xFB -> m_start 2 cycles after req; done[0] pulses once; rx_data=0x000000FB; grant_id=0.
- All four requesters assert req in the same cycle and keep re-requesting -> grant order 0,1,2,3,0; each done exactly once per grant; a request is never starved.
- 32-bit transfer: req[2] with tx=0xC926A05C, len=3, slave tx=0xF97632D4 -> m_len=3 and m_cs_sel=req_cs[2] throughout; rx_data=0xF97632D4 at done[2].
- CPOL switch: req[1] CPOL=1/CPHA=0 after a CPOL=0 job -> m_cpol=1 for at least one SETUP cycle before m_start rises.
- Timeout: m_busy tied low -> m_start high for 15 cycles, then err[grant_id] pulses, done stays low, rx_data unchanged, arb_busy drops.
- Reset mid-RUN: rst low during a 16-bit transfer (len=1) -> all outputs zero asynchronously; after release, a pending req[3] is granted with pointer 0 and no stale done appears.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

   localparam int DATA_W = 32;

   // transaction_length codes understood by spi_master
   localparam logic [1:0] LEN_8  = 2'd0;
   localparam logic [1:0] LEN_16 = 2'd1;
   localparam logic [1:0] LEN_24 = 2'd2;
   localparam logic [1:0] LEN_32 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_START,
      ST_RUN,
      ST_DONE,
      ST_FAIL
   } state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module spi_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid
);

   // Scan from the farthest offset down so the nearest pending requester wins last.
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      idx       = 0;
      gnt_id    = '0;
      gnt_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req[idx[ID_W-1:0]]) begin
            gnt_id    = idx[ID_W-1:0];
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin front end sharing one spi_master between NUM_REQ clients.
// Latches the winner's payload at grant, runs the start/busy handshake and
// returns rx data with a one-cycle done (or err on start timeout) pulse.
module spi_master_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int ID_W          = 2,
   parameter int START_TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_tx_data,
   input  logic [NUM_REQ*3-1:0]      req_cs,
   input  logic [NUM_REQ*2-1:0]      req_len,
   input  logic [NUM_REQ-1:0]        req_cpol,
   input  logic [NUM_REQ-1:0]        req_cpha,
   output logic [NUM_REQ-1:0]        done,
   output logic [NUM_REQ-1:0]        err,
   output logic [DATA_W-1:0]         rx_data,
   output logic [ID_W-1:0]           grant_id,
   output logic                      arb_busy,
   output logic                      m_start,
   input  logic                      m_busy,
   output logic [DATA_W-1:0]         m_tx_data,
   input  logic [DATA_W-1:0]         m_rx_data,
   output logic [2:0]                m_cs_sel,
   output logic [1:0]                m_len,
   output logic                      m_cpol,
   output logic                      m_cpha
);

   state_t              state_q,    state_d;
   logic [ID_W-1:0]     ptr_q,      ptr_d;
   logic [7:0]          cnt_q,      cnt_d;
   logic [NUM_REQ-1:0]  done_q,     done_d;
   logic [NUM_REQ-1:0]  err_q,      err_d;
   logic [DATA_W-1:0]   rx_data_q,  rx_data_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic                arb_busy_q, arb_busy_d;
   logic                m_start_q,  m_start_d;
   logic [DATA_W-1:0]   m_tx_q,     m_tx_d;
   logic [2:0]          m_cs_q,     m_cs_d;
   logic [1:0]          m_len_q,    m_len_d;
   logic                m_cpol_q,   m_cpol_d;
   logic                m_cpha_q,   m_cpha_d;

   logic [ID_W-1:0]     pick_id;
   logic                pick_valid;
   logic [DATA_W-1:0]   sel_tx;
   logic [2:0]          sel_cs;
   logic [1:0]          sel_len;
   logic                sel_cpol;
   logic                sel_cpha;

   spi_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req       (req),
      .ptr       (ptr_q),
      .gnt_id    (pick_id),
      .gnt_valid (pick_valid)
   );

   // Route the payload of the requester the picker currently selects.
   always_comb begin
      sel_tx   = '0;
      sel_cs   = '0;
      sel_len  = '0;
      sel_cpol = 1'b0;
      sel_cpha = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_id == ID_W'(i)) begin
            sel_tx   = req_tx_data[i*DATA_W +: DATA_W];
            sel_cs   = req_cs[i*3 +: 3];
            sel_len  = req_len[i*2 +: 2];
            sel_cpol = req_cpol[i];
            sel_cpha = req_cpha[i];
         end
      end
   end

   // Next-state and registered-output logic for the grant/handshake sequence.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      done_d     = '0;
      err_d      = '0;
      rx_data_d  = rx_data_q;
      grant_id_d = grant_id_q;
      arb_busy_d = arb_busy_q;
      m_start_d  = m_start_q;
      m_tx_d     = m_tx_q;
      m_cs_d     = m_cs_q;
      m_len_d    = m_len_q;
      m_cpol_d   = m_cpol_q;
      m_cpha_d   = m_cpha_q;

      unique case (state_q)
         ST_IDLE: begin
            // A master still finishing a previous job blocks new grants.
            if (pick_valid && !m_busy) begin
               state_d    = ST_SETUP;
               grant_id_d = pick_id;
               arb_busy_d = 1'b1;
               m_tx_d     = sel_tx;
               m_cs_d     = sel_cs;
               m_len_d    = sel_len;
               m_cpol_d   = sel_cpol;
               m_cpha_d   = sel_cpha;
               ptr_d      = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + ID_W'(1);
            end
         end
         ST_SETUP: begin
            // Config has been stable for a cycle; the master now sees the new CPOL idle level.
            state_d   = ST_START;
            m_start_d = 1'b1;
            cnt_d     = '0;
         end
         ST_START: begin
            if (m_busy) begin
               m_start_d = 1'b0;
               state_d   = ST_RUN;
            end else if (cnt_q == 8'(START_TIMEOUT - 1)) begin
               m_start_d           = 1'b0;
               state_d             = ST_FAIL;
               err_d[grant_id_q]   = 1'b1;
               arb_busy_d          = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RUN: begin
            // Capture rx on the busy-fall edge so it is valid alongside the done pulse.
            if (!m_busy) begin
               state_d            = ST_DONE;
               rx_data_d          = m_rx_data;
               done_d[grant_id_q] = 1'b1;
               arb_busy_d         = 1'b0;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_FAIL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any transaction silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
         rx_data_q  <= '0;
         grant_id_q <= '0;
         arb_busy_q <= 1'b0;
         m_start_q  <= 1'b0;
         m_tx_q     <= '0;
         m_cs_q     <= '0;
         m_len_q    <= LEN_8;
         m_cpol_q   <= 1'b0;
         m_cpha_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rx_data_q  <= rx_data_d;
         grant_id_q <= grant_id_d;
         arb_busy_q <= arb_busy_d;
         m_start_q  <= m_start_d;
         m_tx_q     <= m_tx_d;
         m_cs_q     <= m_cs_d;
         m_len_q    <= m_len_d;
         m_cpol_q   <= m_cpol_d;
         m_cpha_q   <= m_cpha_d;
      end
   end

   assign done      = done_q;
   assign err       = err_q;
   assign rx_data   = rx_data_q;
   assign grant_id  = grant_id_q;
   assign arb_busy  = arb_busy_q;
   assign m_start   = m_start_q;
   assign m_tx_data = m_tx_q;
   assign m_cs_sel  = m_cs_q;
   assign m_len     = m_len_q;
   assign m_cpol    = m_cpol_q;
   assign m_cpha    = m_cpha_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: directed scenarios plus a
// randomized phase checked against a transaction-level round-robin model.
module tb_spi_master_arbiter;

   localparam int N = 4;

   logic            clk, rst;
   logic [N-1:0]    req;
   logic [N*32-1:0] req_tx_data;
   logic [N*3-1:0]  req_cs;
   logic [N*2-1:0]  req_len;
   logic [N-1:0]    req_cpol, req_cpha;
   logic [N-1:0]    done, err;
   logic [31:0]     rx_data;
   logic [1:0]      grant_id;
   logic            arb_busy, m_start, m_busy;
   logic [31:0]     m_tx_data, m_rx_data;
   logic [2:0]      m_cs_sel;
   logic [1:0]      m_len;
   logic            m_cpol, m_cpha;

   spi_master_arbiter #(.NUM_REQ(N), .ID_W(2), .START_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .req(req), .req_tx_data(req_tx_data), .req_cs(req_cs),
      .req_len(req_len), .req_cpol(req_cpol), .req_cpha(req_cpha), .done(done), .err(err),
      .rx_data(rx_data), .grant_id(grant_id), .arb_busy(arb_busy), .m_start(m_start),
      .m_busy(m_busy), .m_tx_data(m_tx_data), .m_rx_data(m_rx_data), .m_cs_sel(m_cs_sel),
      .m_len(m_len), .m_cpol(m_cpol), .m_cpha(m_cpha)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // requester-side stimulus state
   logic [N-1:0] req_v;
   logic [31:0]  tx_a   [N];
   logic [2:0]   cs_a   [N];
   logic [1:0]   len_a  [N];
   logic         cpol_a [N];
   logic         cpha_a [N];

   // snapshot of what the DUT sampled on the most recent edge
   logic [N-1:0] snap_req;
   logic [31:0]  snap_tx   [N];
   logic [2:0]   snap_cs   [N];
   logic [1:0]   snap_len  [N];
   logic         snap_cpol [N];
   logic         snap_cpha [N];

   // behavioural slave state
   bit          slave_en, fixed_mode;
   logic [31:0] fixed_resp;
   int          s_wait, s_cnt, s_delay, s_len_cycles;

   logic [31:0] last_rx;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] resp_of(input logic [31:0] t);
      return {t[7:0], t[31:8]} ^ 32'hA5C3_0F69;
   endfunction

   task automatic drive();
      req = req_v;
      for (int i = 0; i < N; i++) begin
         req_tx_data[i*32 +: 32] = tx_a[i];
         req_cs[i*3 +: 3]        = cs_a[i];
         req_len[i*2 +: 2]       = len_a[i];
         req_cpol[i]             = cpol_a[i];
         req_cpha[i]             = cpha_a[i];
      end
   endtask

   task automatic take_snap();
      snap_req = req_v;
      for (int i = 0; i < N; i++) begin
         snap_tx[i] = tx_a[i]; snap_cs[i] = cs_a[i]; snap_len[i] = len_a[i];
         snap_cpol[i] = cpol_a[i]; snap_cpha[i] = cpha_a[i];
      end
   endtask

   // One clock of the behavioural SPI slave, evaluated at the falling edge.
   task automatic slave_step();
      if (slave_en) begin
         if (!m_busy) begin
            if (m_start) begin
               if (s_wait >= s_delay) begin
                  m_busy       = 1'b1;
                  m_rx_data    = fixed_mode ? fixed_resp : resp_of(m_tx_data);
                  s_cnt        = 0;
                  s_wait       = 0;
                  s_len_cycles = 2 * (int'(m_len) + 1);
                  s_delay      = $urandom_range(0, 3);
               end else begin
                  s_wait++;
               end
            end
         end else begin
            s_cnt++;
            if (s_cnt >= s_len_cycles) m_busy = 1'b0;
         end
      end
   endtask

   task automatic tick();
      drive();
      @(negedge clk);
      slave_step();
   endtask

   task automatic wait_event(input string tag);
      for (int c = 0; c < 200; c++) begin
         tick();
         if (done != '0 || err != '0) return;
      end
      check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mstart"}, m_start, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_busy"}, arb_busy, 0);
      check({tag, "_rx"}, rx_data, 0);
      check({tag, "_mtx"}, m_tx_data, 0);
      check({tag, "_mcs"}, m_cs_sel, 0);
      check({tag, "_mlen"}, m_len, 0);
      check({tag, "_mcpol"}, m_cpol, 0);
      check({tag, "_mcpha"}, m_cpha, 0);
      check({tag, "_gid"}, grant_id, 0);
   endtask

   task automatic new_payload(input int i);
      tx_a[i]   = $urandom;
      cs_a[i]   = 3'($urandom_range(0, 7));
      len_a[i]  = 2'($urandom_range(0, 3));
      cpol_a[i] = 1'($urandom_range(0, 1));
      cpha_a[i] = 1'($urandom_range(0, 1));
   endtask

   // Lone request: latency, latched config, payload isolation and rx return.
   task automatic run_one(input string tag, input int id, input logic [31:0] tx, input logic [2:0] cs,
                          input logic [1:0] len, input logic cpol, input logic cpha, input logic [31:0] resp);
      slave_en = 1; fixed_mode = 1; fixed_resp = resp;
      tx_a[id] = tx; cs_a[id] = cs; len_a[id] = len; cpol_a[id] = cpol; cpha_a[id] = cpha;
      req_v[id] = 1'b1;
      tick();
      check({tag, "_busy"}, arb_busy, 1);
      check({tag, "_gid"}, grant_id, id);
      check({tag, "_setup_mstart"}, m_start, 0);
      check({tag, "_setup_cpol"}, m_cpol, cpol);
      check({tag, "_cpha"}, m_cpha, cpha);
      tx_a[id] = ~tx;                       // later payload edits must be ignored
      tick();
      check({tag, "_mstart"}, m_start, 1);
      check({tag, "_mtx"}, m_tx_data, tx);
      check({tag, "_mcs"}, m_cs_sel, cs);
      check({tag, "_mlen"}, m_len, len);
      wait_event(tag);
      check({tag, "_done"}, done, 32'(1) << id);
      check({tag, "_err"}, err, 0);
      check({tag, "_rx"}, rx_data, resp);
      check({tag, "_done_busy"}, arb_busy, 0);
      check({tag, "_done_mcs"}, m_cs_sel, cs);
      check({tag, "_done_mlen"}, m_len, len);
      last_rx = resp;
      req_v[id] = 1'b0;
      tick();
      check({tag, "_pulse"}, done, 0);
      tick();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k, n, exp_id, ptr_m, fl_id, stall;
      logic [31:0] fl_tx;
      logic busy_prev, start_chk;
      int served [N];

      rst = 1'b0; m_busy = 1'b0; m_rx_data = '0;
      slave_en = 0; fixed_mode = 0; fixed_resp = '0;
      s_wait = 0; s_cnt = 0; s_delay = 0; s_len_cycles = 2;
      req_v = '0; last_rx = '0;
      for (int i = 0; i < N; i++) begin
         tx_a[i] = '0; cs_a[i] = '0; len_a[i] = '0; cpol_a[i] = 0; cpha_a[i] = 0; served[i] = 0;
      end

      // reset state
      tick(); tick();
      check_reset_outputs("reset");
      rst = 1'b1;
      tick();

      // all four request together and keep requesting: 0,1,2,3,0
      slave_en = 1; fixed_mode = 0;
      for (int i = 0; i < N; i++) begin
         new_payload(i);
         cs_a[i] = 3'(i);
         req_v[i] = 1'b1;
      end
      k = 0;
      for (int c = 0; c < 400 && k < 5; c++) begin
         tick();
         if (done != '0) begin
            check("rr_done", done, 32'(1) << (k % N));
            check("rr_gid", grant_id, k % N);
            check("rr_rx", rx_data, resp_of(tx_a[k % N]));
            last_rx = resp_of(tx_a[k % N]);
            k++;
         end
      end
      check("rr_count", k, 5);
      req_v = '0;
      tick(); tick(); tick();

      run_one("single", 0, 32'h0000_00AA, 3'd0, 2'd0, 1'b0, 1'b1, 32'h0000_00FB);
      run_one("len32",  2, 32'hC926_A05C, 3'd5, 2'd3, 1'b0, 1'b0, 32'hF976_32D4);
      run_one("cpol",   1, 32'h1234_5678, 3'd2, 2'd1, 1'b1, 1'b0, 32'h0BAD_F00D);

      // master still busy in IDLE: no grant until it goes idle
      slave_en = 0; m_busy = 1'b1;
      new_payload(3); req_v[3] = 1'b1;
      repeat (4) tick();
      check("bsyidle_hold", arb_busy, 0);
      check("bsyidle_mstart", m_start, 0);
      m_busy = 1'b0;
      tick();
      check("bsyidle_grant", arb_busy, 1);
      check("bsyidle_gid", grant_id, 3);
      slave_en = 1; fixed_mode = 0; s_wait = 0;
      wait_event("bsyidle");
      check("bsyidle_done", done, 32'h8);
      last_rx = rx_data;
      check("bsyidle_rx", rx_data, resp_of(tx_a[3]));
      req_v[3] = 1'b0;
      tick(); tick();

      // start timeout: master never answers
      slave_en = 0; m_busy = 1'b0;
      new_payload(1); req_v[1] = 1'b1;
      tick();
      check("to_grant", arb_busy, 1);
      n = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (m_start) n++;
         else if (n > 0) break;
      end
      check("to_len", n, 15);
      check("to_err", err, 32'h2);
      check("to_done", done, 0);
      check("to_rx", rx_data, last_rx);
      check("to_busy", arb_busy, 0);
      req_v[1] = 1'b0;
      tick();
      check("to_pulse", err, 0);
      tick();

      // reset in the middle of a 16-bit transfer
      slave_en = 1; fixed_mode = 1; fixed_resp = 32'h0000_5555; s_wait = 0;
      new_payload(0); len_a[0] = 2'd1; req_v[0] = 1'b1;
      n = 0;
      while (!m_busy && n < 40) begin tick(); n++; end
      check("midrst_run", m_busy, 1);
      tick();
      new_payload(3); req_v[3] = 1'b1;
      drive();
      #2 rst = 1'b0;
      #1 check_reset_outputs("midrst");
      slave_en = 0; m_busy = 1'b0; req_v[0] = 1'b0; s_wait = 0; s_cnt = 0;
      tick(); tick();
      rst = 1'b1;
      slave_en = 1; fixed_resp = 32'h3C3C_A5A5;
      wait_event("midrst");
      check("midrst_done", done, 32'h8);
      check("midrst_rx", rx_data, 32'h3C3C_A5A5);
      req_v[3] = 1'b0;
      tick(); tick();

      // randomized phase against a transaction-level round-robin model
      fixed_mode = 0;
      ptr_m = 0;                          // last grant went to requester 3
      fl_id = 0; fl_tx = '0; start_chk = 0; stall = 0;
      busy_prev = arb_busy;
      take_snap();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit drain;
         drain = (cyc >= 2600);
         tick();
         if (arb_busy && !busy_prev) begin
            exp_id = -1;
            for (int o = 0; o < N; o++) begin
               int j;
               j = (ptr_m + o) % N;
               if (snap_req[j] && exp_id < 0) exp_id = j;
            end
            if (exp_id < 0) begin
               check("rand_spurious_grant", 32'd1, 32'd0);
               exp_id = 0;
            end
            check("rand_gid", grant_id, exp_id);
            check("rand_mtx", m_tx_data, snap_tx[exp_id]);
            check("rand_mcs", m_cs_sel, snap_cs[exp_id]);
            check("rand_mlen", m_len, snap_len[exp_id]);
            check("rand_pol", {m_cpol, m_cpha}, {snap_cpol[exp_id], snap_cpha[exp_id]});
            check("rand_setup", m_start, 0);
            ptr_m = (exp_id + 1) % N;
            fl_id = exp_id; fl_tx = snap_tx[exp_id]; start_chk = 1;
         end else if (start_chk) begin
            check("rand_start", m_start, 1);
            start_chk = 0;
         end
         if (err != '0) check("rand_err", err, 0);
         if (done != '0) begin
            check("rand_done", done, 32'(1) << fl_id);
            check("rand_rx", rx_data, resp_of(fl_tx));
            served[fl_id]++;
            stall = 0;
            req_v[fl_id] = (!drain && $urandom_range(0, 1) == 1);
            if (req_v[fl_id]) new_payload(fl_id);
         end
         if (req_v != '0 || arb_busy) stall++;
         else stall = 0;
         if (stall > 200) begin
            check("rand_stall", stall, 0);
            break;
         end
         for (int i = 0; i < N; i++) begin
            if (!req_v[i] && !drain && $urandom_range(0, 3) == 0) begin
               req_v[i] = 1'b1;
               new_payload(i);
            end else if (req_v[i] && $urandom_range(0, 7) == 0) begin
               tx_a[i] = $urandom;
            end
         end
         take_snap();
         busy_prev = arb_busy;
      end
      for (int i = 0; i < N; i++) check($sformatf("rand_served%0d", i), 32'(served[i] > 0), 1);
      check("rand_drain_busy", arb_busy, 0);
      check("rand_drain_req", req_v, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
